// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 demux scheduler.
// Holds channel count, select width, mode encodings and the holding-register state.
package demux_pkg;

    localparam int SEL_W = 2;
    localparam int N_OUT = 4;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_ptr.sv
// Wrapping round-robin channel pointer with advance enable.
// Ports: clk, rst (sync, active-high), adv (step by one), ptr (current channel).
module rr_ptr
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [SEL_W-1:0] ptr
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // Natural 2-bit overflow gives the 3 -> 0 wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/demux_scheduler.sv
// Sequencing controller for a 1:4 demux: one-entry output register, RR or fixed routing.
// Ports: clk/rst, in_valid/in_data/in_ready, mode/fix_sel, out_valid/out_data/out_ready,
// sel (demux select), busy (word held), stall_cnt (saturating stalled-cycle count).
module demux_scheduler
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   fix_sel,
    output logic [N_OUT-1:0]   out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [N_OUT-1:0]   out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cnt
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [SEL_W-1:0]   ptr;
    logic               tgt_ready;
    logic               full;
    logic               accept;
    logic               deliver;

    assign full      = (state_q == FULL);
    // Only the selected channel's ready matters; others never let a word skip ahead.
    assign tgt_ready = out_ready[sel_q];
    assign in_ready  = !rst && (!full || tgt_ready);
    assign accept    = in_valid && in_ready;
    assign deliver   = full && tgt_ready;

    rr_ptr u_rr_ptr (
        .clk (clk),
        .rst (rst),
        .adv (accept && (mode == MODE_RR)),
        .ptr (ptr)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        stall_d = stall_q;
        // An accept in a delivering cycle refills the register (pass-through).
        if (accept) begin
            state_d = FULL;
            data_d  = in_data;
            sel_d   = (mode == MODE_FIX) ? fix_sel : ptr;
        end else if (deliver) begin
            state_d = EMPTY;
        end
        if (full && !tgt_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            sel_q   <= '0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < N_OUT; i++) begin
            out_valid[i] = full && (sel_q == SEL_W'(i));
        end
    end

    assign out_data  = data_q;
    assign sel       = sel_q;
    assign busy      = full;
    assign stall_cnt = stall_q;

endmodule
